// File: rtl/mem_block_responder.sv
// -----------------------------------------------------------------------------
// mem_block_responder
//
// Main-memory side responder for cache block refills and write-backs. It takes
// one block request at a time over a valid/ready handshake and waits a fixed
// access latency. It then moves one block word by word in ascending order and
// pulses done for one cycle when the block is finished.
//
// Ports:
//   clk          single clock, rising edge
//   reset        asynchronous, active-high reset
//   req_valid    cache presents a block request
//   req_ready    high only while idle; accept on req_valid && req_ready
//   read_write   1 = write block, 0 = read block (sampled at acceptance)
//   address      byte address (sampled at acceptance)
//   write_data   write-beat data (sampled at the edge ending each write beat)
//   write_ready  high during each write beat
//   read_data    read-beat data, 0 outside read beats
//   read_valid   high during each read beat
//   beat_index   0-based index of the current beat
//   done         one-cycle completion pulse
// -----------------------------------------------------------------------------
module mem_block_responder #(
    parameter int ADDR_W          = 10,
    parameter int WORDS_PER_BLOCK = 4,
    parameter int LATENCY         = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                read_write,
    input  logic [ADDR_W-1:0]   address,
    input  logic [31:0]         write_data,
    output logic                write_ready,
    output logic [31:0]         read_data,
    output logic                read_valid,
    output logic [((WORDS_PER_BLOCK > 1) ? $clog2(WORDS_PER_BLOCK) : 1)-1:0] beat_index,
    output logic                done
);

    localparam int WI_W     = ADDR_W - 2;
    localparam int DEPTH    = 2 ** WI_W;
    localparam int BI_W     = (WORDS_PER_BLOCK > 1) ? $clog2(WORDS_PER_BLOCK) : 1;
    localparam int LAT_W    = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam int LAT_LAST = (LATENCY > 0) ? LATENCY - 1 : 0;

    localparam logic [WI_W-1:0] BLK_MASK  = WI_W'(WORDS_PER_BLOCK - 1);
    localparam logic [BI_W-1:0] BEAT_LAST = BI_W'(WORDS_PER_BLOCK - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_XFER = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t            state_q;
    logic              req_ready_q;
    logic              read_valid_q;
    logic              write_ready_q;
    logic              done_q;
    logic [31:0]       read_data_q;
    logic [BI_W-1:0]   beat_q;
    logic [LAT_W-1:0]  lat_q;
    logic              wr_q;
    logic [WI_W-1:0]   base_q;

    // Storage keeps each word XOR its own index. A zero power-up image
    // therefore reads back as word i = i without any initialisation pass, and
    // reset leaves the contents alone.
    logic [31:0]       mem_q [DEPTH];

    logic [WI_W-1:0]   base_d;
    logic [WI_W-1:0]   beat_addr_d;
    logic [WI_W-1:0]   rd_addr_d;
    logic [31:0]       rd_word_d;
    logic [1:0]        addr_unused_d;

    // Byte offset is irrelevant for word-wide blocks.
    assign addr_unused_d = address[1:0];

    // Block base drops the in-block word bits, so any address inside a block
    // selects the same beats.
    assign base_d      = address[ADDR_W-1:2] & ~BLK_MASK;
    assign beat_addr_d = base_q + WI_W'(beat_q);

    // Select the word the next read beat will present: beat 0 on entry to the
    // transfer, otherwise the word after the current beat (wraps modulo DEPTH).
    always_comb begin
        rd_addr_d = base_q;
        if (state_q == S_IDLE) begin
            rd_addr_d = base_d;
        end else if (state_q == S_XFER) begin
            rd_addr_d = beat_addr_d + WI_W'(1);
        end else begin
            rd_addr_d = base_q;
        end
    end

    assign rd_word_d = mem_q[rd_addr_d] ^ 32'(rd_addr_d);

    // Commit a write beat at the edge that ends it; storage has no reset.
    always_ff @(posedge clk) begin
        if ((state_q == S_XFER) && wr_q) begin
            mem_q[beat_addr_d] <= write_data ^ 32'(beat_addr_d);
        end
    end

    // Transfer sequencer with registered handshake and beat outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            req_ready_q   <= 1'b1;
            read_valid_q  <= 1'b0;
            write_ready_q <= 1'b0;
            done_q        <= 1'b0;
            read_data_q   <= 32'h0000_0000;
            beat_q        <= '0;
            lat_q         <= '0;
            wr_q          <= 1'b0;
            base_q        <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (req_valid && req_ready_q) begin
                        wr_q        <= read_write;
                        base_q      <= base_d;
                        req_ready_q <= 1'b0;
                        lat_q       <= '0;
                        beat_q      <= '0;
                        if (LATENCY == 0) begin
                            state_q       <= S_XFER;
                            read_valid_q  <= ~read_write;
                            write_ready_q <= read_write;
                            read_data_q   <= read_write ? 32'h0000_0000 : rd_word_d;
                        end else begin
                            state_q <= S_WAIT;
                        end
                    end else begin
                        req_ready_q <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (lat_q == LAT_W'(LAT_LAST)) begin
                        state_q       <= S_XFER;
                        beat_q        <= '0;
                        read_valid_q  <= ~wr_q;
                        write_ready_q <= wr_q;
                        read_data_q   <= wr_q ? 32'h0000_0000 : rd_word_d;
                    end else begin
                        lat_q <= lat_q + LAT_W'(1);
                    end
                end
                S_XFER: begin
                    if (beat_q == BEAT_LAST) begin
                        state_q       <= S_DONE;
                        beat_q        <= '0;
                        read_valid_q  <= 1'b0;
                        write_ready_q <= 1'b0;
                        read_data_q   <= 32'h0000_0000;
                        done_q        <= 1'b1;
                    end else begin
                        beat_q      <= beat_q + BI_W'(1);
                        read_data_q <= wr_q ? 32'h0000_0000 : rd_word_d;
                    end
                end
                S_DONE: begin
                    // req_ready stays low through DONE, so the earliest new
                    // acceptance is at the end of the following idle period.
                    state_q     <= S_IDLE;
                    done_q      <= 1'b0;
                    req_ready_q <= 1'b1;
                end
                default: begin
                    state_q       <= S_IDLE;
                    req_ready_q   <= 1'b1;
                    read_valid_q  <= 1'b0;
                    write_ready_q <= 1'b0;
                    done_q        <= 1'b0;
                    read_data_q   <= 32'h0000_0000;
                    beat_q        <= '0;
                    lat_q         <= '0;
                end
            endcase
        end
    end

    assign req_ready   = req_ready_q;
    assign read_valid  = read_valid_q;
    assign write_ready = write_ready_q;
    assign read_data   = read_data_q;
    assign beat_index  = beat_q;
    assign done        = done_q;

endmodule

// File: tb/tb_mem_block_responder.sv
// Scoreboard bench for mem_block_responder: the driver pushes expected beats and
// done events (with their cycle numbers) at acceptance, and a monitor pops them
// whenever the DUT shows read_valid, write_ready or done.
module tb_mem_block_responder;

    localparam int ADDR_W = 10;
    localparam int WPB    = 4;
    localparam int LAT    = 3;
    localparam int DEPTH  = 256;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        read_write;
    logic [9:0]  address;
    logic [31:0] write_data;
    logic        write_ready;
    logic [31:0] read_data;
    logic        read_valid;
    logic [1:0]  beat_index;
    logic        done;

    mem_block_responder #(
        .ADDR_W(ADDR_W),
        .WORDS_PER_BLOCK(WPB),
        .LATENCY(LAT)
    ) dut (
        .clk(clk),
        .reset(reset),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .read_write(read_write),
        .address(address),
        .write_data(write_data),
        .write_ready(write_ready),
        .read_data(read_data),
        .read_valid(read_valid),
        .beat_index(beat_index),
        .done(done)
    );

    // cyc = number of rising edges so far; the period after edge E has cyc == E.
    int cyc;
    initial begin
        clk = 1'b0;
        cyc = 0;
        forever begin
            #5 clk = 1'b1;
            cyc = cyc + 1;
            #5 clk = 1'b0;
        end
    end

    typedef struct {
        int          cyc;
        int          kind;   // 0 read beat, 1 write beat, 2 done
        int          idx;
        logic [31:0] data;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] ref_mem [DEPTH];
    int          n_chk;
    int          n_fail;
    int          busy_lo;
    int          busy_hi;
    logic        wr_active;
    int          wr_start;
    int          wr_base;
    logic [31:0] wr_vals [WPB];
    logic [31:0] wr_next [WPB];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_req_ready"}, 32'(req_ready), 32'd1);
        chk({tag, "_read_valid"}, 32'(read_valid), 32'd0);
        chk({tag, "_write_ready"}, 32'(write_ready), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_read_data"}, read_data, 32'd0);
        chk({tag, "_beat_index"}, 32'(beat_index), 32'd0);
    endtask

    // Reference model: block of aligned words, fixed latency, one beat per cycle.
    task automatic model_accept(input logic [9:0] a, input logic rw, input int acc);
        int   base;
        exp_t e;
        base = ((int'(a) / 4) / WPB) * WPB;
        for (int b = 0; b < WPB; b++) begin
            e.cyc  = acc + LAT + b;
            e.kind = rw ? 1 : 0;
            e.idx  = b;
            e.data = rw ? 32'd0 : ref_mem[(base + b) % DEPTH];
            sb.push_back(e);
        end
        e.cyc  = acc + LAT + WPB;
        e.kind = 2;
        e.idx  = 0;
        e.data = 32'd0;
        sb.push_back(e);
        busy_lo = acc;
        busy_hi = acc + LAT + WPB;
        if (rw) begin
            wr_base  = base;
            wr_start = acc + LAT;
            for (int b = 0; b < WPB; b++) wr_vals[b] = wr_next[b];
            wr_active = 1'b1;
        end
    endtask

    task automatic issue(input logic [9:0] a, input logic rw, input logic keep, output int acc);
        int n;
        @(negedge clk);
        req_valid  = 1'b1;
        address    = a;
        read_write = rw;
        n = 0;
        while (!req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            n_chk++;
            n_fail++;
            $display("FAIL accept_timeout: req_ready %0b after %0d cycles, expected 1", req_ready, n);
            req_valid = 1'b0;
            acc = -1;
        end else begin
            @(posedge clk);
            #1;
            acc = cyc;
            model_accept(a, rw, acc);
            if (keep) begin
                // Keep asking with a different request while busy.
                address    = a ^ 10'h100;
                read_write = ~rw;
            end else begin
                req_valid = 1'b0;
            end
        end
    endtask

    task automatic wait_idle();
        while (cyc <= busy_hi + 1) @(negedge clk);
    endtask

    // Write-data driver: supplies each planned beat and commits it to the
    // model at the edge ending the beat unless reset intervened.
    initial begin
        int b;
        write_data = 32'd0;
        forever begin
            @(negedge clk);
            if (wr_active && cyc >= wr_start && cyc < wr_start + WPB) begin
                b = cyc - wr_start;
                write_data = wr_vals[b];
                @(posedge clk);
                if (!reset && wr_active) ref_mem[(wr_base + b) % DEPTH] = wr_vals[b];
            end else begin
                write_data = $urandom;
            end
        end
    end

    // Monitor: pops the scoreboard whenever the DUT shows a beat or done.
    initial begin
        exp_t e;
        int   kind;
        forever begin
            @(negedge clk);
            if (!reset) begin
                chk("rv_wr_exclusive", 32'(read_valid & write_ready), 32'd0);
                if (!read_valid) chk("read_data_idle", read_data, 32'd0);
                chk("req_ready", 32'(req_ready),
                    (cyc >= busy_lo && cyc <= busy_hi) ? 32'd0 : 32'd1);
                if (read_valid || write_ready || done) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_output", 32'({read_valid, write_ready, done}), 32'd0);
                    end else begin
                        e    = sb.pop_front();
                        kind = done ? 2 : (write_ready ? 1 : 0);
                        chk("event_cycle", 32'(cyc), 32'(e.cyc));
                        chk("event_kind", 32'(kind), 32'(e.kind));
                        if (e.kind != 2) chk("beat_index", 32'(beat_index), 32'(e.idx));
                        if (e.kind == 0) chk("read_data", read_data, e.data);
                    end
                end else if (sb.size() > 0 && cyc >= sb[0].cyc) begin
                    chk("missing_event", 32'(cyc), 32'(sb[0].cyc));
                    void'(sb.pop_front());
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        int a1;
        int a2;
        n_chk      = 0;
        n_fail     = 0;
        busy_lo    = 1;
        busy_hi    = 0;
        wr_active  = 1'b0;
        wr_start   = 0;
        wr_base    = 0;
        req_valid  = 1'b0;
        read_write = 1'b0;
        address    = 10'h000;
        reset      = 1'b0;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'(i);
        for (int b = 0; b < WPB; b++) begin
            wr_vals[b] = 32'd0;
            wr_next[b] = 32'd0;
        end
        #1 reset = 1'b1;

        // Reset held two cycles, then idle with no request.
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);

        // Aligned read of words 4..7.
        issue(10'h010, 1'b0, 1'b0, acc);
        wait_idle();

        // Write A0..A3 to words 8..11, then read them back.
        for (int b = 0; b < WPB; b++) wr_next[b] = 32'hA0 + 32'(b);
        issue(10'h020, 1'b1, 1'b0, acc);
        wait_idle();
        issue(10'h020, 1'b0, 1'b0, acc);
        wait_idle();

        // Unaligned address inside the same block as 10'h010.
        issue(10'h01E, 1'b0, 1'b0, acc);
        wait_idle();

        // Request held high with a different address while busy.
        issue(10'h010, 1'b0, 1'b1, a1);
        issue(10'h110, 1'b0, 1'b0, a2);
        chk("reaccept_cycle", 32'(a2), 32'(a1 + LAT + WPB + 2));
        wait_idle();

        // Write to words 16..19 aborted by reset right after beat 0 commits.
        for (int b = 0; b < WPB; b++) wr_next[b] = 32'hB000 + 32'(b);
        issue(10'h040, 1'b1, 1'b0, acc);
        while (cyc < acc + LAT + 1) @(posedge clk);
        #1;
        reset     = 1'b1;
        sb.delete();
        wr_active = 1'b0;
        busy_lo   = 1;
        busy_hi   = 0;
        #1;
        check_reset_outputs("abort");
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        issue(10'h040, 1'b0, 1'b0, acc);
        wait_idle();

        // Randomized traffic.
        for (int k = 0; k < 30; k++) begin
            for (int b = 0; b < WPB; b++) wr_next[b] = $urandom;
            repeat ($urandom_range(0, 3)) @(negedge clk);
            issue(10'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0), acc);
        end
        @(negedge clk);
        req_valid = 1'b0;
        wait_idle();
        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
